// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions.
// SEG7_PATTERN[n] is the raw active-low segment pattern (bit0=a .. bit6=g) that
// shows hex digit n. The hex->segment encoder and the segment->hex decoder both
// read this table, so the two directions cannot disagree.
package seg7_pkg;

  localparam logic [6:0] SEG7_BLANK = 7'h7F;

  localparam logic [6:0] SEG7_PATTERN [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/seg7_scan_decoder_if.sv
// Output side of seg7_scan_decoder: valid/ready frame result plus overrun status.
//   out_valid   frame in value/digit_err is complete
//   out_ready   consumer accepts the frame this cycle
//   value       4 bits per digit, digit i at [4i+3:4i]
//   digit_err   bit i = digit i showed a non-hex pattern
//   overrun     sticky frame-dropped flag
//   clr_overrun clears overrun
// master = decoder side, slave = consumer side.
interface seg7_scan_decoder_if #(
  parameter int unsigned NUM_DIGITS = 4
);
  logic                      out_valid;
  logic                      out_ready;
  logic [4*NUM_DIGITS-1:0]   value;
  logic [NUM_DIGITS-1:0]     digit_err;
  logic                      overrun;
  logic                      clr_overrun;

  modport master (
    output out_valid, value, digit_err, overrun,
    input  out_ready, clr_overrun
  );

  modport slave (
    input  out_valid, value, digit_err, overrun,
    output out_ready, clr_overrun
  );
endinterface

// File: rtl/seg7_to_hex.sv
// Combinational segment->hex decoder.
//   seg    raw active-low segment pattern, bit0=a .. bit6=g
//   nibble decoded hex value (0 when err)
//   err    pattern is not one of the 16 hex glyphs (blank included)
module seg7_to_hex
  import seg7_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] nibble,
  output logic       err
);

  always_comb begin
    nibble = 4'h0;
    err    = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (seg == SEG7_PATTERN[i]) begin
        nibble = 4'(i);
        err    = 1'b0;
      end
    end
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Captures a multiplexed 7-segment display from its pins and rebuilds the shown
// hex word, one word per scan frame.
//   clk, rst  single clock, synchronous active-high reset
//   seg_in    segment lines (active-low), bit0=a .. bit6=g
//   an_in     digit enables, polarity set by ACTIVE_LOW_AN
//   bus       result interface (master side), see seg7_scan_decoder_if
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS    = 4,
  parameter int unsigned STABLE_CYCLES = 8,
  parameter bit          ACTIVE_LOW_AN = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [6:0]            seg_in,
  input  logic [NUM_DIGITS-1:0] an_in,
  seg7_scan_decoder_if.master   bus
);

  localparam int unsigned CntW = $clog2(STABLE_CYCLES);
  localparam logic [NUM_DIGITS-1:0] AnIdle = {NUM_DIGITS{ACTIVE_LOW_AN}};
  localparam logic [CntW-1:0] CntHit = CntW'(STABLE_CYCLES - 1);

  // Two-flop synchronisers plus a one-cycle history for the dwell compare.
  logic [6:0]            seg_s1_q, seg_s2_q, seg_prev_q;
  logic [NUM_DIGITS-1:0] an_s1_q, an_s2_q, an_prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      seg_s1_q   <= SEG7_BLANK;
      seg_s2_q   <= SEG7_BLANK;
      seg_prev_q <= SEG7_BLANK;
      an_s1_q    <= AnIdle;
      an_s2_q    <= AnIdle;
      an_prev_q  <= AnIdle;
    end else begin
      seg_s1_q   <= seg_in;
      seg_s2_q   <= seg_s1_q;
      seg_prev_q <= seg_s2_q;
      an_s1_q    <= an_in;
      an_s2_q    <= an_s1_q;
      an_prev_q  <= an_s2_q;
    end
  end

  logic [NUM_DIGITS-1:0] an_act;
  logic                  digit_ok, stable, capture;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  taken_q, taken_d;
  logic [3:0]            dec_nib;
  logic                  dec_err;

  assign an_act   = ACTIVE_LOW_AN ? ~an_s2_q : an_s2_q;
  // Exactly one enable active; several or none means "no digit".
  assign digit_ok = (an_act != '0) && ((an_act & (an_act - NUM_DIGITS'(1))) == '0);
  assign stable   = (seg_s2_q == seg_prev_q) && (an_s2_q == an_prev_q);
  // stable also guards against sampling a pattern that changed on the capture cycle.
  assign capture  = stable && (cnt_q == CntHit) && !taken_q && digit_ok;

  seg7_to_hex u_dec (
    .seg    (seg_s2_q),
    .nibble (dec_nib),
    .err    (dec_err)
  );

  always_comb begin
    cnt_d   = cnt_q;
    taken_d = taken_q;
    if (!stable) begin
      cnt_d   = '0;
      taken_d = 1'b0;
    end else begin
      if (cnt_q != '1) cnt_d = cnt_q + CntW'(1);
      if (capture) taken_d = 1'b1;
    end
  end

  // Frame staging. The mask is the one-hot set of digits captured so far; seeing
  // an already captured digit again means a new scan started, so restart from it.
  logic [3:0]            nib_q [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] err_q;
  logic [NUM_DIGITS-1:0] mask_q, mask_d, mask_base;
  logic                  complete_q, complete_d;

  always_comb begin
    mask_base = complete_q ? '0 : mask_q;
    mask_d    = mask_base;
    if (capture) begin
      mask_d = ((mask_base & an_act) != '0) ? an_act : (mask_base | an_act);
    end
    complete_d = capture && (mask_d == '1);
  end

  // Output register and sticky overrun.
  logic                    out_valid_q, out_valid_d;
  logic [4*NUM_DIGITS-1:0] value_q, value_d;
  logic [NUM_DIGITS-1:0]   derr_q, derr_d;
  logic                    overrun_q, overrun_d;
  logic                    drop;

  always_comb begin
    out_valid_d = out_valid_q;
    value_d     = value_q;
    derr_d      = derr_q;
    drop        = 1'b0;
    if (complete_q) begin
      if (!out_valid_q || bus.out_ready) begin
        out_valid_d = 1'b1;
        derr_d      = err_q;
        for (int i = 0; i < int'(NUM_DIGITS); i++) value_d[4*i +: 4] = nib_q[i];
      end else begin
        drop = 1'b1;
      end
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end
    overrun_d = drop ? 1'b1 : (bus.clr_overrun ? 1'b0 : overrun_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      taken_q     <= 1'b0;
      mask_q      <= '0;
      complete_q  <= 1'b0;
      err_q       <= '0;
      out_valid_q <= 1'b0;
      value_q     <= '0;
      derr_q      <= '0;
      overrun_q   <= 1'b0;
      for (int i = 0; i < int'(NUM_DIGITS); i++) nib_q[i] <= 4'h0;
    end else begin
      cnt_q       <= cnt_d;
      taken_q     <= taken_d;
      mask_q      <= mask_d;
      complete_q  <= complete_d;
      out_valid_q <= out_valid_d;
      value_q     <= value_d;
      derr_q      <= derr_d;
      overrun_q   <= overrun_d;
      if (capture) begin
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
          if (an_act[i]) begin
            nib_q[i] <= dec_nib;
            err_q[i] <= dec_err;
          end
        end
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.value     = value_q;
  assign bus.digit_err = derr_q;
  assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed bench for seg7_scan_decoder (4 digits, 8-cycle dwell, active-low an).
module tb_seg7_scan_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] seg_in;
  logic [3:0] an_in;

  int checks   = 0;
  int failures = 0;

  seg7_scan_decoder_if #(.NUM_DIGITS(4)) bus_if ();

  seg7_scan_decoder #(
    .NUM_DIGITS    (4),
    .STABLE_CYCLES (8),
    .ACTIVE_LOW_AN (1'b1)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .seg_in (seg_in),
    .an_in  (an_in),
    .bus    (bus_if)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // All stimulus changes and samples happen 1 time unit after a rising edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input int d, input logic [6:0] seg, input int n);
    an_in  = ~(4'b0001 << d);
    seg_in = seg;
    tick(n);
  endtask

  task automatic idle(input int n);
    an_in  = 4'hF;
    seg_in = 7'h7F;
    tick(n);
  endtask

  task automatic consume();
    bus_if.out_ready = 1'b1;
    tick(1);
    bus_if.out_ready = 1'b0;
  endtask

  int lat;

  initial begin
    rst                = 1'b1;
    an_in              = 4'hF;
    seg_in             = 7'h7F;
    bus_if.out_ready   = 1'b0;
    bus_if.clr_overrun = 1'b0;
    tick(3);
    rst = 1'b0;
    tick(1);

    check_eq("rst_valid",   32'(bus_if.out_valid), 32'd0);
    check_eq("rst_value",   32'(bus_if.value),     32'h0);
    check_eq("rst_err",     32'(bus_if.digit_err), 32'h0);
    check_eq("rst_overrun", 32'(bus_if.overrun),   32'd0);

    // 1: clean frame 0,1,2,3 and latency of the final digit
    drive(0, 7'h40, 20);
    drive(1, 7'h79, 20);
    drive(2, 7'h24, 20);
    an_in  = 4'b0111;
    seg_in = 7'h30;
    lat = 0;
    for (int i = 1; i <= 30; i++) begin
      tick(1);
      if (bus_if.out_valid && lat == 0) lat = i;
    end
    check_eq("t1_latency", 32'(lat),              32'd12);
    check_eq("t1_value",   32'(bus_if.value),     32'h3210);
    check_eq("t1_err",     32'(bus_if.digit_err), 32'h0);
    idle(15);
    check_eq("t1_hold",    32'(bus_if.out_valid), 32'd1);
    consume();
    check_eq("t1_drain",   32'(bus_if.out_valid), 32'd0);

    // 2: blank on digit 2, blank gaps with no digit enabled
    drive(0, 7'h40, 20); idle(20);
    drive(1, 7'h79, 20); idle(20);
    drive(2, 7'h7F, 20); idle(20);
    drive(3, 7'h30, 20); idle(5);
    check_eq("t2_value", 32'(bus_if.value),     32'h3010);
    check_eq("t2_err",   32'(bus_if.digit_err), 32'h4);
    consume();

    // 3: digit 0 glitching must never complete a frame of otherwise ready digits
    drive(1, 7'h24, 20);
    drive(2, 7'h30, 20);
    drive(3, 7'h19, 20);
    an_in = 4'b1110;
    for (int i = 0; i < 20; i++) begin
      seg_in = (i % 2 == 0) ? 7'h40 : 7'h79;
      tick(3);
    end
    idle(10);
    check_eq("t3_glitch_valid", 32'(bus_if.out_valid), 32'd0);
    drive(0, 7'h12, 20);
    check_eq("t3_after_valid",  32'(bus_if.out_valid), 32'd1);
    check_eq("t3_after_value",  32'(bus_if.value),     32'h4325);
    consume();

    // 4: two frames with out_ready low -> first kept, second dropped
    drive(0, 7'h0E, 20); drive(1, 7'h06, 20); drive(2, 7'h21, 20); drive(3, 7'h46, 20);
    drive(0, 7'h08, 20); drive(1, 7'h03, 20); drive(2, 7'h02, 20); drive(3, 7'h78, 20);
    idle(5);
    check_eq("t4_valid",   32'(bus_if.out_valid), 32'd1);
    check_eq("t4_value",   32'(bus_if.value),     32'hCDEF);
    check_eq("t4_overrun", 32'(bus_if.overrun),   32'd1);
    bus_if.clr_overrun = 1'b1;
    tick(1);
    bus_if.clr_overrun = 1'b0;
    check_eq("t4_clr",     32'(bus_if.overrun),   32'd0);
    consume();
    check_eq("t4_drain",   32'(bus_if.out_valid), 32'd0);

    // 5: digit 1 recaptured before digit 3 restarts the frame
    drive(0, 7'h10, 20);
    drive(1, 7'h00, 20);
    drive(1, 7'h78, 20);
    drive(2, 7'h02, 20);
    drive(3, 7'h12, 20);
    check_eq("t5_early", 32'(bus_if.out_valid), 32'd0);
    drive(0, 7'h19, 20);
    check_eq("t5_valid", 32'(bus_if.out_valid), 32'd1);
    check_eq("t5_value", 32'(bus_if.value),     32'h5674);

    // 6: reset with a published frame and two staged digits
    drive(0, 7'h40, 20);
    drive(1, 7'h79, 20);
    an_in  = 4'hF;
    seg_in = 7'h7F;
    rst    = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(1);
    check_eq("t6_rst_valid", 32'(bus_if.out_valid), 32'd0);
    check_eq("t6_rst_value", 32'(bus_if.value),     32'h0);
    drive(2, 7'h30, 20);
    drive(3, 7'h19, 20);
    check_eq("t6_no_stale",  32'(bus_if.out_valid), 32'd0);
    drive(0, 7'h79, 20);
    drive(1, 7'h12, 20);
    check_eq("t6_valid",     32'(bus_if.out_valid), 32'd1);
    check_eq("t6_value",     32'(bus_if.value),     32'h4351);
    check_eq("t6_err",       32'(bus_if.digit_err), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
